// File: rtl/noc_flit_ejector.sv
// ============================================================================
// noc_flit_ejector
// ----------------------------------------------------------------------------
// Terminating endpoint for one router output link. Flits arrive under the
// NoC send/credit protocol and are buffered in a small FIFO. They leave as a
// single-clock AXI-Stream master. One credit pulse is returned upstream for
// every flit drained. The block also watches the link for two protocol
// violations: a flit arriving with no free slot, and a destination change in
// the middle of a packet.
//
// Optional feature macro: NOC_EJECT_STATS_EN
//   When defined, adds the flit_cnt / pkt_cnt statistics outputs.
//   When undefined, those ports and their logic do not exist.
//
// Ports:
//   clk_noc       in   sole clock, all logic on posedge
//   rst_noc       in   synchronous active-high reset
//   data_in       in   flit payload
//   dest_in       in   flit destination, {tid, tdest}
//   is_tail_in    in   last flit of packet
//   send_in       in   flit valid this cycle (no backpressure)
//   credit_out    out  one-cycle pulse per drained flit
//   axis_tvalid   out  AXIS valid (FIFO not empty)
//   axis_tready   in   AXIS ready from the sink
//   axis_tdata    out  head flit payload
//   axis_tlast    out  head flit tail marker
//   axis_tid      out  head flit dest upper field
//   axis_tdest    out  head flit dest lower field
//   overflow_err  out  sticky: flit arrived while the FIFO was full
//   proto_err     out  sticky: destination changed inside a packet
//   flit_cnt      out  (NOC_EJECT_STATS_EN) number of flits popped
//   pkt_cnt       out  (NOC_EJECT_STATS_EN) number of tail flits popped
// ============================================================================
module noc_flit_ejector #(
    parameter int FLIT_WIDTH        = 64,
    parameter int TDEST_WIDTH       = 2,
    parameter int TID_WIDTH         = 2,
    parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
    parameter int FLIT_BUFFER_DEPTH = 8
) (
    input  logic                   clk_noc,
    input  logic                   rst_noc,

    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,

    output logic                   axis_tvalid,
    input  logic                   axis_tready,
    output logic [FLIT_WIDTH-1:0]  axis_tdata,
    output logic                   axis_tlast,
    output logic [TID_WIDTH-1:0]   axis_tid,
    output logic [TDEST_WIDTH-1:0] axis_tdest,

    output logic                   overflow_err,
    output logic                   proto_err
`ifdef NOC_EJECT_STATS_EN
    ,
    output logic [31:0]            flit_cnt,
    output logic [31:0]            pkt_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------------
    localparam int PTR_W = $clog2(FLIT_BUFFER_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FLIT_BUFFER_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------------
    logic [FLIT_WIDTH-1:0] data_mem [FLIT_BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0] dest_mem [FLIT_BUFFER_DEPTH];
    logic                  tail_mem [FLIT_BUFFER_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic push;
    logic pop;
    logic is_full;
    logic accept;
    logic drop;

    assign push    = send_in;
    assign pop     = axis_tvalid & axis_tready;
    assign is_full = (count == FULL_COUNT);

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, because the freed slot is the one being written next.
    assign accept = push & (~is_full | pop);
    assign drop   = push & is_full & ~pop;

    // ------------------------------------------------------------------------
    // AXIS output: the head entry is read straight from registered storage.
    // While stalled, neither rd_ptr nor the head slot can change (a write
    // only targets the head slot once the FIFO has drained), so all axis_*
    // outputs hold stable.
    // ------------------------------------------------------------------------
    logic [DEST_WIDTH-1:0] head_dest;

    assign axis_tvalid = (count != '0);
    assign axis_tdata  = data_mem[rd_ptr];
    assign axis_tlast  = tail_mem[rd_ptr];
    assign head_dest   = dest_mem[rd_ptr];
    assign axis_tdest  = head_dest[TDEST_WIDTH-1:0];
    assign axis_tid    = head_dest[DEST_WIDTH-1:TDEST_WIDTH];

    // ------------------------------------------------------------------------
    // Storage write port. The array carries no reset: stale contents are
    // never visible because tvalid gates them.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_noc) begin
        if (accept) begin
            data_mem[wr_ptr] <= data_in;
            dest_mem[wr_ptr] <= dest_in;
            tail_mem[wr_ptr] <= is_tail_in;
        end
    end

    // ------------------------------------------------------------------------
    // Pointer, occupancy, credit return and overflow detection.
    // Pointers are exactly log2(DEPTH) bits so they wrap for free.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            credit_out   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({accept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // Credits follow pops only; dropped flits never consumed a slot.
            credit_out <= pop;

            if (drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Input-side packet tracker. It follows accepted flits only, so a flit
    // dropped on overflow neither opens nor closes a packet.
    // ------------------------------------------------------------------------
    typedef enum logic {
        TRK_IDLE = 1'b0,
        TRK_BODY = 1'b1
    } trk_state_t;

    trk_state_t            trk_state;
    logic [DEST_WIDTH-1:0] pkt_dest;

    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            trk_state <= TRK_IDLE;
            pkt_dest  <= '0;
            proto_err <= 1'b0;
        end else if (accept) begin
            case (trk_state)
                TRK_IDLE: begin
                    // A tail seen here is a single-flit packet: stay idle.
                    if (!is_tail_in) begin
                        pkt_dest  <= dest_in;
                        trk_state <= TRK_BODY;
                    end
                end
                TRK_BODY: begin
                    if (dest_in != pkt_dest) begin
                        proto_err <= 1'b1;
                    end
                    if (is_tail_in) begin
                        trk_state <= TRK_IDLE;
                    end
                end
                default: trk_state <= TRK_IDLE;
            endcase
        end
    end

`ifdef NOC_EJECT_STATS_EN
    // ------------------------------------------------------------------------
    // Drain statistics. Both counters wrap naturally at 2^32.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            flit_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (pop) begin
            flit_cnt <= flit_cnt + 32'd1;
            if (axis_tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_flit_ejector.sv
// ============================================================================
// tb_noc_flit_ejector
// ----------------------------------------------------------------------------
// Self-checking bench for noc_flit_ejector. A behavioural model (a queue of
// buffered flits plus a few flags) is advanced at every clock edge from the
// stimulus the bench applies; each test task compares the DUT outputs
// against that model or against constants of its own.
// ============================================================================
module tb_noc_flit_ejector;

    localparam int FW    = 64;
    localparam int DW    = 4;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
    } flit_t;

    logic          clk_noc = 1'b0;
    logic          rst_noc;
    logic [FW-1:0] data_in;
    logic [DW-1:0] dest_in;
    logic          is_tail_in;
    logic          send_in;
    logic          credit_out;
    logic          axis_tvalid;
    logic          axis_tready;
    logic [FW-1:0] axis_tdata;
    logic          axis_tlast;
    logic [1:0]    axis_tid;
    logic [1:0]    axis_tdest;
    logic          overflow_err;
    logic          proto_err;
`ifdef NOC_EJECT_STATS_EN
    logic [31:0]   flit_cnt;
    logic [31:0]   pkt_cnt;
`endif

    noc_flit_ejector #(
        .FLIT_WIDTH        (FW),
        .TDEST_WIDTH       (2),
        .TID_WIDTH         (2),
        .DEST_WIDTH        (DW),
        .FLIT_BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk_noc      (clk_noc),
        .rst_noc      (rst_noc),
        .data_in      (data_in),
        .dest_in      (dest_in),
        .is_tail_in   (is_tail_in),
        .send_in      (send_in),
        .credit_out   (credit_out),
        .axis_tvalid  (axis_tvalid),
        .axis_tready  (axis_tready),
        .axis_tdata   (axis_tdata),
        .axis_tlast   (axis_tlast),
        .axis_tid     (axis_tid),
        .axis_tdest   (axis_tdest),
        .overflow_err (overflow_err),
        .proto_err    (proto_err)
`ifdef NOC_EJECT_STATS_EN
        ,
        .flit_cnt     (flit_cnt),
        .pkt_cnt      (pkt_cnt)
`endif
    );

    always #5 clk_noc = ~clk_noc;

    int errors = 0;
    int checks = 0;

    // Reference model state
    flit_t        mq[$];
    logic         exp_credit;
    logic         m_ovf;
    logic         m_proto;
    logic         m_in_pkt;
    logic [DW-1:0] m_pkt_dest;
    int unsigned  m_flits;
    int unsigned  m_pkts;

    // Advance the model by one clock edge using the inputs as applied.
    task automatic model_edge();
        bit    pop;
        bit    ok;
        flit_t f;
        if (rst_noc) begin
            mq.delete();
            exp_credit = 1'b0;
            m_ovf      = 1'b0;
            m_proto    = 1'b0;
            m_in_pkt   = 1'b0;
            m_pkt_dest = '0;
            m_flits    = 0;
            m_pkts     = 0;
            return;
        end
        pop = (mq.size() != 0) && axis_tready;
        ok  = send_in && ((mq.size() < DEPTH) || pop);
        exp_credit = pop;
        if (pop) begin
            f = mq.pop_front();
            m_flits++;
            if (f.tail) m_pkts++;
        end
        if (send_in && !ok) m_ovf = 1'b1;
        if (ok) begin
            mq.push_back({data_in, dest_in, is_tail_in});
            if (!m_in_pkt) begin
                if (!is_tail_in) begin
                    m_in_pkt   = 1'b1;
                    m_pkt_dest = dest_in;
                end
            end else begin
                if (dest_in != m_pkt_dest) m_proto = 1'b1;
                if (is_tail_in) m_in_pkt = 1'b0;
            end
        end
    endtask

    // Apply one cycle of stimulus; starts and ends at a negedge.
    task automatic cycle(input logic s, input logic [FW-1:0] d, input logic [DW-1:0] de,
                         input logic t, input logic r);
        send_in     = s;
        data_in     = d;
        dest_in     = de;
        is_tail_in  = t;
        axis_tready = r;
        @(posedge clk_noc);
        model_edge();
        @(negedge clk_noc);
    endtask

    task automatic do_reset();
        rst_noc     = 1'b1;
        send_in     = 1'b0;
        axis_tready = 1'b0;
        @(posedge clk_noc);
        model_edge();
        @(negedge clk_noc);
        rst_noc = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        // Put some state in first so the reset has something to clear.
        do_reset();
        cycle(1'b1, 64'h1234, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 64'h5678, 4'h2, 1'b1, 1'b0);
        do_reset();
        checks++; if (axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b want 0", axis_tvalid); end
        checks++; if (credit_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_credit: got %b want 0", credit_out); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow_err); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto: got %b want 0", proto_err); end
`ifdef NOC_EJECT_STATS_EN
        checks++; if (flit_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_flit_cnt: got %0d want 0", flit_cnt); end
        checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
`endif
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single_flit();
        do_reset();
        cycle(1'b1, 64'hA5, 4'b1001, 1'b1, 1'b1);
        checks++; if (axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_tvalid: got %b want 1", axis_tvalid); end
        checks++; if (axis_tdata !== 64'hA5) begin errors++; $display("[TB] FAIL single_tdata: got %h want a5", axis_tdata); end
        checks++; if (axis_tid !== 2'b10) begin errors++; $display("[TB] FAIL single_tid: got %b want 10", axis_tid); end
        checks++; if (axis_tdest !== 2'b01) begin errors++; $display("[TB] FAIL single_tdest: got %b want 01", axis_tdest); end
        checks++; if (axis_tlast !== 1'b1) begin errors++; $display("[TB] FAIL single_tlast: got %b want 1", axis_tlast); end
        checks++; if (credit_out !== 1'b0) begin errors++; $display("[TB] FAIL single_credit_early: got %b want 0", credit_out); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        checks++; if (credit_out !== 1'b1) begin errors++; $display("[TB] FAIL single_credit: got %b want 1", credit_out); end
        checks++; if (axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained: got %b want 0", axis_tvalid); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        checks++; if (credit_out !== 1'b0) begin errors++; $display("[TB] FAIL single_credit_once: got %b want 0", credit_out); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_fill();
        logic [FW-1:0] d [DEPTH];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            d[i] = {$urandom, $urandom};
            cycle(1'b1, d[i], 4'h6, (i == DEPTH - 1), 1'b0);
            checks++; if (credit_out !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_credit[%0d]: got %b want 0", i, credit_out); end
        end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL fill_overflow: got %b want 0", overflow_err); end
        checks++; if (mq.size() != DEPTH) begin errors++; $display("[TB] FAIL fill_count: got %0d want %0d", mq.size(), DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (axis_tvalid !== 1'b1 || axis_tdata !== d[i]) begin errors++; $display("[TB] FAIL fill_order[%0d]: got v=%b %h want v=1 %h", i, axis_tvalid, axis_tdata, d[i]); end
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
            checks++; if (credit_out !== 1'b1) begin errors++; $display("[TB] FAIL fill_credit[%0d]: got %b want 1", i, credit_out); end
        end
        checks++; if (axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty: got %b want 0", axis_tvalid); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        checks++; if (credit_out !== 1'b0) begin errors++; $display("[TB] FAIL fill_credit_end: got %b want 0", credit_out); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_overflow();
        logic [FW-1:0] d [DEPTH];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            d[i] = {$urandom, $urandom};
            cycle(1'b1, d[i], 4'h2, 1'b1, 1'b0);
        end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before: got %b want 0", overflow_err); end
        cycle(1'b1, 64'hDEAD_BEEF_0000_0009, 4'h2, 1'b1, 1'b0);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b want 1", overflow_err); end
        checks++; if (credit_out !== 1'b0) begin errors++; $display("[TB] FAIL ovf_no_credit: got %b want 0", credit_out); end
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (axis_tvalid !== 1'b1 || axis_tdata !== d[i]) begin errors++; $display("[TB] FAIL ovf_order[%0d]: got v=%b %h want v=1 %h", i, axis_tvalid, axis_tdata, d[i]); end
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
        end
        checks++; if (axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_dropped: got tvalid %b want 0", axis_tvalid); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow_err); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_full_push_pop();
        logic [FW-1:0] d [DEPTH];
        logic [FW-1:0] e [DEPTH];
        logic [FW-1:0] x;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            d[i] = {$urandom, $urandom};
            cycle(1'b1, d[i], 4'h7, 1'b1, 1'b0);
        end
        x = {$urandom, $urandom};
        cycle(1'b1, x, 4'h7, 1'b1, 1'b1);
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL fpp_overflow: got %b want 0", overflow_err); end
        checks++; if (credit_out !== 1'b1) begin errors++; $display("[TB] FAIL fpp_credit: got %b want 1", credit_out); end
        for (int i = 0; i < DEPTH; i++) e[i] = (i < DEPTH - 1) ? d[i + 1] : x;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (axis_tvalid !== 1'b1 || axis_tdata !== e[i]) begin errors++; $display("[TB] FAIL fpp_order[%0d]: got v=%b %h want v=1 %h", i, axis_tvalid, axis_tdata, e[i]); end
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
        end
        checks++; if (axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL fpp_count: got tvalid %b want 0", axis_tvalid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_proto();
        logic [FW-1:0] d [3];
        do_reset();
        // Consistent packets, including a destination change between packets.
        cycle(1'b1, 64'h10, 4'h3, 1'b0, 1'b1);
        cycle(1'b1, 64'h11, 4'h3, 1'b1, 1'b1);
        cycle(1'b1, 64'h12, 4'h6, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL proto_clean: got %b want 0", proto_err); end
        for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom};
        cycle(1'b1, d[0], 4'h3, 1'b0, 1'b0);
        cycle(1'b1, d[1], 4'h3, 1'b0, 1'b0);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL proto_early: got %b want 0", proto_err); end
        cycle(1'b1, d[2], 4'h5, 1'b1, 1'b0);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL proto_set: got %b want 1", proto_err); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (axis_tvalid !== 1'b1 || axis_tdata !== d[i]) begin errors++; $display("[TB] FAIL proto_deliver[%0d]: got v=%b %h want v=1 %h", i, axis_tvalid, axis_tdata, d[i]); end
            if (i == 2) begin
                checks++; if (axis_tdest !== 2'b01 || axis_tid !== 2'b01 || axis_tlast !== 1'b1) begin errors++; $display("[TB] FAIL proto_tail_fields: got tid=%b tdest=%b tlast=%b want 01 01 1", axis_tid, axis_tdest, axis_tlast); end
            end
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
        end
        cycle(1'b1, 64'h20, 4'h2, 1'b0, 1'b1);
        cycle(1'b1, 64'h21, 4'h2, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL proto_sticky: got %b want 1", proto_err); end
        checks++; if (overflow_err !== 1'b0 || axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL proto_after: got ovf=%b tvalid=%b want 0 0", overflow_err, axis_tvalid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        int cyc;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 64'(i + 100), 4'h4, (i % 4 == 3), 1'b1);
            if (i > 0) begin
                checks++; if (credit_out !== 1'b1) begin errors++; $display("[TB] FAIL b2b_credit[%0d]: got %b want 1", i, credit_out); end
            end
            checks++; if (axis_tvalid !== 1'b1 || axis_tdata !== 64'(i + 100)) begin errors++; $display("[TB] FAIL b2b_head[%0d]: got v=%b %h want v=1 %h", i, axis_tvalid, axis_tdata, 64'(i + 100)); end
        end
        cyc = 0;
        while (mq.size() != 0 && cyc < 20) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
            cyc++;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        int          sent;
        int          cyc;
        int          credits_seen;
        int          tails_sent;
        logic        s;
        logic        r;
        logic        t;
        logic        in_pkt;
        logic [DW-1:0] cur_dest;
        logic [FW-1:0] d;
        logic        stall;
        logic [FW-1:0] snap_data;
        logic        snap_last;
        logic [1:0]  snap_tid;
        logic [1:0]  snap_tdest;
        do_reset();
        sent = 0; cyc = 0; credits_seen = 0; tails_sent = 0;
        in_pkt = 1'b0; cur_dest = '0;
        while ((sent < 1000 || mq.size() != 0) && cyc < 20000) begin
            s = (sent < 1000) && (mq.size() < DEPTH) && ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 1) == 1);
            d = {$urandom, $urandom};
            t = ($urandom_range(0, 2) == 0) || (sent == 999);
            if (s && !in_pkt) cur_dest = DW'($urandom);
            stall      = axis_tvalid && !r;
            snap_data  = axis_tdata;
            snap_last  = axis_tlast;
            snap_tid   = axis_tid;
            snap_tdest = axis_tdest;
            cycle(s, d, cur_dest, t, r);
            if (s) begin
                sent++;
                if (t) tails_sent++;
                in_pkt = !t;
            end
            cyc++;
            if (credit_out === 1'b1) credits_seen++;
            checks++; if (axis_tvalid !== (mq.size() != 0)) begin errors++; $display("[TB] FAIL rnd_tvalid@%0d: got %b want %b", cyc, axis_tvalid, (mq.size() != 0)); end
            checks++; if (credit_out !== exp_credit) begin errors++; $display("[TB] FAIL rnd_credit@%0d: got %b want %b", cyc, credit_out, exp_credit); end
            if (mq.size() != 0) begin
                checks++; if ({axis_tdata, axis_tid, axis_tdest, axis_tlast} !== mq[0]) begin errors++; $display("[TB] FAIL rnd_head@%0d: got %h/%b%b/%b want %h/%b/%b", cyc, axis_tdata, axis_tid, axis_tdest, axis_tlast, mq[0].data, mq[0].dest, mq[0].tail); end
            end
            if (stall) begin
                checks++; if (axis_tdata !== snap_data || axis_tlast !== snap_last || axis_tid !== snap_tid || axis_tdest !== snap_tdest) begin errors++; $display("[TB] FAIL rnd_stall_stable@%0d: got %h want %h", cyc, axis_tdata, snap_data); end
            end
        end
        checks++; if (cyc >= 20000) begin errors++; $display("[TB] FAIL rnd_timeout: got %0d flits sent, %0d left, want all drained", sent, mq.size()); end
        checks++; if (credits_seen !== 1000) begin errors++; $display("[TB] FAIL rnd_credit_total: got %0d want 1000", credits_seen); end
        checks++; if (overflow_err !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("[TB] FAIL rnd_errors: got ovf=%b proto=%b want 0 0", overflow_err, proto_err); end
`ifdef NOC_EJECT_STATS_EN
        checks++; if (flit_cnt !== 32'd1000) begin errors++; $display("[TB] FAIL rnd_flit_cnt: got %0d want 1000", flit_cnt); end
        checks++; if (pkt_cnt !== 32'(tails_sent)) begin errors++; $display("[TB] FAIL rnd_pkt_cnt: got %0d want %0d", pkt_cnt, tails_sent); end
`endif
    endtask

    // ------------------------------------------------------------------------
    initial begin
        rst_noc     = 1'b1;
        send_in     = 1'b0;
        data_in     = '0;
        dest_in     = '0;
        is_tail_in  = 1'b0;
        axis_tready = 1'b0;
        @(negedge clk_noc);
        test_reset();
        test_single_flit();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_proto();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_flit_ejector.md
# noc_flit_ejector

Terminating endpoint for one router output link: accepts flits under the NoC send/credit flow-control protocol, buffers them, and presents them as a single-clock AXI-Stream master. It returns one credit per flit drained. It sits between a router output port and user logic wherever the serializer/deserializer shim is not needed. It also checks the link for protocol violations.

## Interface
Parameters:
- FLIT_WIDTH, 64: flit data width; also the AXIS tdata width.
- TDEST_WIDTH, 2: AXIS tdest width.
- TID_WIDTH, 2: AXIS tid width.
- DEST_WIDTH, TDEST_WIDTH+TID_WIDTH: link dest field width.
- FLIT_BUFFER_DEPTH, 8: FIFO entries. Must be a power of 2, ≥2. Equals the upstream credit count.

Ports:
- clk_noc  in  1  sole clock. Everything is posedge.
- rst_noc  in  1  reset, synchronous, active-high.
- data_in  in  FLIT_WIDTH  flit payload.
- dest_in  in  DEST_WIDTH  flit destination, as {tid, tdest}.
- is_tail_in  in  1  last flit of packet.
- send_in  in  1  flit valid this cycle. No backpressure.
- credit_out  out  1  one-cycle pulse; returns one buffer slot upstream.
- axis_tvalid  out  1  output flit valid.
- axis_tready  in  1  sink ready.
- axis_tdata  out  FLIT_WIDTH  equals data.
- axis_tlast  out  1  equals is_tail.
- axis_tid  out  TID_WIDTH  dest[DEST_WIDTH-1:TDEST_WIDTH].
- axis_tdest  out  TDEST_WIDTH  dest[TDEST_WIDTH-1:0].
- overflow_err  out  1  sticky; flit arrived with no free slot.
- proto_err  out  1  sticky; dest changed mid-packet.

## Operation
- FIFO storage: FLIT_BUFFER_DEPTH entries of {data, dest, tail}.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- push = send_in. pop = axis_tvalid & axis_tready. axis_tvalid = (count != 0).
- Push when count == DEPTH and no pop: the flit is dropped, no pointer or count change, and overflow_err is set.
- Push at count == DEPTH with a simultaneous pop is accepted; count stays DEPTH.
- Simultaneous push and pop at count 0 is impossible, since tvalid = 0. The flit is written normally.
- Credit: credit_out <= pop, registered. Exactly one pulse per popped flit. Dropped flits never return credit.
- Packet tracker, input side, two states:
  - IDLE: an accepted non-tail flit latches pkt_dest <= dest_in and moves to BODY. A tail flit in IDLE is a single-flit packet and stays in IDLE.
  - BODY: each accepted flit with dest_in != pkt_dest sets proto_err. The flit is still stored. An accepted tail flit returns to IDLE.
  - Dropped (overflow) flits do not advance the tracker.
- Error flags are cleared only by rst_noc.

## Timing
- Reset, taking effect at the first posedge with rst_noc = 1:
  - count = 0, pointers = 0, tracker IDLE.
  - axis_tvalid = 0, credit_out = 0, overflow_err = 0, proto_err = 0.
  - axis_tdata, tid, tdest and tlast are don't-care while tvalid = 0.
- Reset mid-operation discards buffered flits and in-flight credits. Upstream must be reset in the same cycle.
- Latency from send_in at edge N:
  - axis_tvalid is high after edge N, when the FIFO was empty.
  - 1-cycle fall-through is not provided. Data is registered.
- Latency from a pop at edge N: credit_out is high for cycle N+1 only.
- Back-to-back: one push and one pop per cycle, sustained. Full throughput with axis_tready held high.
- AXIS rule: while axis_tvalid = 1 and axis_tready = 0, all axis_* outputs hold stable.

## Configuration
- NOC_EJECT_STATS_EN, when defined:
  - Adds output flit_cnt [31:0], counting pops.
  - Adds output pkt_cnt [31:0], counting pops with tlast.
  - Both reset to 0 and wrap at 2^32.
- When undefined: these ports and their logic do not exist. All other behaviour is identical.

## Test plan
- Reset, then a single-flit packet: send_in = 1, data = 0xA5, dest = 4'b1001, tail = 1, axis_tready = 1.
  - Next cycle: tvalid = 1, tdata = 0xA5, tid = 2'b10, tdest = 2'b01, tlast = 1.
  - The cycle after: credit_out pulses once.
- Fill: 8 flits with tready = 0.
  - count = 8, no credits, overflow_err = 0.
  - Then raise tready: 8 pops in order, and 8 credit pulses on consecutive cycles.
- Overflow: push a 9th flit while full with tready = 0.
  - overflow_err = 1 and stays 1.
  - Only the original 8 flits emerge.
- Full with simultaneous push and pop: push is accepted, count stays 8, overflow_err = 0, order is preserved.
- Protocol check: 3-flit packet with dest 0x3, 0x3, 0x5 (tail).
  - proto_err = 1.
  - All 3 flits are delivered.
  - A following packet with consistent dest leaves no further effect.
- Random tready stall pattern over 1000 flits: data order is preserved, credits total 1000, tdata is stable during stalls.
  - With NOC_EJECT_STATS_EN: flit_cnt equals 1000 and pkt_cnt equals the number of tails.
